alu_limb_seq: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle datapath ALU of the ECC core.
- Processes WORD_SIZE operands limb-serially, LIMB bits per clock, so wide field words (e.g. 256-bit) close timing without a full-width carry chain.
- Also computes PC-relative branch targets in one cycle.
- Sits between the register-file read stage and writeback, using a valid/ready handshake.

---
 rtl/alu_limb_seq_if.sv | 36 +++
 rtl/alu_limb_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_limb_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_limb_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_limb_seq_if                                               |
// | Brief    : Request/response bundle between the register-file read stage, |
// |            the limb-serial ALU and writeback.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface alu_limb_seq_if #(
  parameter int WORD_SIZE = 64,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
);
  logic                 i_valid;
  logic                 o_ready;
  logic [INSN:0]        i_insn;
  logic [IADDR:0]       i_pc;
  logic [WORD_SIZE-1:0] i_r1data;
  logic [WORD_SIZE-1:0] i_r2data;
  logic                 i_carry;
  logic [WORD_SIZE-1:0] o_result;
  logic                 o_carry;
  logic                 o_valid;

  // Requester side: issues operations, consumes results
  modport master (
    output i_valid, i_insn, i_pc, i_r1data, i_r2data, i_carry,
    input  o_ready, o_result, o_carry, o_valid
  );

  // ALU side
  modport slave (
    input  i_valid, i_insn, i_pc, i_r1data, i_r2data, i_carry,
    output o_ready, o_result, o_carry, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/alu_limb_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_limb_seq                                                  |
// | Brief    : Limb-serial ALU. Arithmetic/logic/shift ops walk the operand  |
// |            LIMB bits per clock with a registered inter-limb carry;       |
// |            branch targets complete in one cycle. Optional shift-add      |
// |            multiplier enabled by defining ALU_LIMB_MUL_EN.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_limb_seq #(
  parameter int WORD_SIZE = 64,
  parameter int LIMB      = 16,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
) (
  input logic          i_clk,
  input logic          i_rst,
  alu_limb_seq_if.slave bus
);
  localparam int NLIMB = WORD_SIZE / LIMB;
  localparam int CW    = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] c_last_limb = CW'(NLIMB - 1);
`ifdef ALU_LIMB_MUL_EN
  localparam logic [CW-1:0] c_last_bit  = CW'(WORD_SIZE - 1);
`endif

  localparam logic [4:0] c_op_nop  = 5'b00000;
  localparam logic [4:0] c_op_brz  = 5'b00001;
  localparam logic [4:0] c_op_brzp = 5'b00010;
  localparam logic [4:0] c_op_brnp = 5'b00011;
  localparam logic [4:0] c_op_brnz = 5'b00100;
  localparam logic [4:0] c_op_add  = 5'b00101;
  localparam logic [4:0] c_op_adc  = 5'b00110;
  localparam logic [4:0] c_op_sub  = 5'b00111;
  localparam logic [4:0] c_op_sbb  = 5'b01000;
  localparam logic [4:0] c_op_and  = 5'b01001;
  localparam logic [4:0] c_op_or   = 5'b01010;
  localparam logic [4:0] c_op_xor  = 5'b01011;
  localparam logic [4:0] c_op_shl1 = 5'b01100;
  localparam logic [4:0] c_op_shr1 = 5'b01101;
`ifdef ALU_LIMB_MUL_EN
  localparam logic [4:0] c_op_mul  = 5'b01110;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] a_q, a_d;
  logic [WORD_SIZE-1:0] b_q, b_d;
  logic                 carry_q, carry_d;     // inter-limb carry/borrow
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] shadow_q, shadow_d;   // partial result (hi product in MUL)
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 valid_q, valid_d;

  logic [4:0]           w_opcode;
  logic [IADDR:0]       w_br_target;
  logic [31:0]          w_off32;
  logic [INSN-14:0]     unused_insn_bits;

  logic                 w_msb_first;
  logic [LIMB-1:0]      w_a_limb, w_b_limb, w_limb_res;
  logic                 w_limb_cout;
  logic [LIMB:0]        w_add_ext, w_sub_ext, w_shl_ext, w_shr_ext;
  logic [WORD_SIZE-1:0] w_shadow_next;
`ifdef ALU_LIMB_MUL_EN
  logic [WORD_SIZE:0]   w_mul_sum;
  logic [WORD_SIZE:0]   w_mul_lo;
`endif

  assign w_opcode         = bus.i_insn[INSN -: 5];
  assign unused_insn_bits = bus.i_insn[INSN-5:9];
  assign w_off32          = {{23{bus.i_insn[8]}}, bus.i_insn[8:0]};
  assign w_br_target      = bus.i_pc + w_off32[IADDR:0];

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_result = result_q;
  assign bus.o_carry  = cout_q;
  assign bus.o_valid  = valid_q;

  // One-limb datapath: SHR1 consumes limbs from the top, everything else from the bottom
  always_comb begin
    w_msb_first = (op_q == c_op_shr1);
    w_a_limb    = w_msb_first ? a_q[WORD_SIZE-1 -: LIMB] : a_q[LIMB-1:0];
    w_b_limb    = b_q[LIMB-1:0];
    w_add_ext   = {1'b0, w_a_limb} + {1'b0, w_b_limb} + {{LIMB{1'b0}}, carry_q};
    w_sub_ext   = {1'b0, w_a_limb} - {1'b0, w_b_limb} - {{LIMB{1'b0}}, carry_q};
    w_shl_ext   = {w_a_limb, carry_q};
    w_shr_ext   = {carry_q, w_a_limb};
    w_limb_res  = '0;
    w_limb_cout = 1'b0;
    case (op_q)
      c_op_add, c_op_adc: begin w_limb_res = w_add_ext[LIMB-1:0]; w_limb_cout = w_add_ext[LIMB]; end
      c_op_sub, c_op_sbb: begin w_limb_res = w_sub_ext[LIMB-1:0]; w_limb_cout = w_sub_ext[LIMB]; end
      c_op_and:           w_limb_res = w_a_limb & w_b_limb;
      c_op_or:            w_limb_res = w_a_limb | w_b_limb;
      c_op_xor:           w_limb_res = w_a_limb ^ w_b_limb;
      c_op_shl1:   begin w_limb_res = w_shl_ext[LIMB-1:0]; w_limb_cout = w_shl_ext[LIMB]; end
      c_op_shr1:   begin w_limb_res = w_shr_ext[LIMB:1];   w_limb_cout = w_shr_ext[0];    end
      default: ;
    endcase
    w_shadow_next = w_msb_first ? ((shadow_q << LIMB) | WORD_SIZE'(w_limb_res))
                                : ((shadow_q >> LIMB) | (WORD_SIZE'(w_limb_res) << (WORD_SIZE - LIMB)));
  end

  // Sequencer next-state: accept, limb walk, optional multiply, completion pulse
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    result_d = result_q;
    cout_d   = cout_q;
    valid_d  = 1'b0;
`ifdef ALU_LIMB_MUL_EN
    w_mul_sum = {1'b0, shadow_q} + (b_q[0] ? {1'b0, a_q} : '0);
    w_mul_lo  = {w_mul_sum[0], b_q};
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          op_d     = w_opcode;
          a_d      = bus.i_r1data;
          b_d      = bus.i_r2data;
          cnt_d    = '0;
          shadow_d = '0;
          carry_d  = 1'b0;
          case (w_opcode)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor: state_d = ST_RUN;
            c_op_adc, c_op_sbb, c_op_shl1, c_op_shr1: begin
              carry_d = bus.i_carry;
              state_d = ST_RUN;
            end
            c_op_brz, c_op_brzp, c_op_brnp, c_op_brnz: begin
              result_d             = '0;
              result_d[IADDR:0]    = w_br_target;
              cout_d               = 1'b0;
              valid_d              = 1'b1;
              state_d              = ST_DONE;
            end
`ifdef ALU_LIMB_MUL_EN
            c_op_mul: state_d = ST_MUL;
`endif
            default: begin
              // NOP and unrecognised opcodes complete immediately with zero
              result_d = '0;
              cout_d   = 1'b0;
              valid_d  = 1'b1;
              state_d  = ST_DONE;
            end
          endcase
        end
      end
      ST_RUN: begin
        shadow_d = w_shadow_next;
        a_d      = w_msb_first ? (a_q << LIMB) : (a_q >> LIMB);
        b_d      = b_q >> LIMB;
        carry_d  = w_limb_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == c_last_limb) begin
          result_d = w_shadow_next;
          cout_d   = w_limb_cout;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
`ifdef ALU_LIMB_MUL_EN
      ST_MUL: begin
        // Right-shifting shift-add: shadow holds the high half, b the low half
        shadow_d = w_mul_sum[WORD_SIZE:1];
        b_d      = w_mul_lo[WORD_SIZE:1];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == c_last_bit) begin
          result_d = w_mul_lo[WORD_SIZE:1];
          cout_d   = |w_mul_sum[WORD_SIZE:1];
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      op_q     <= c_op_nop;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      valid_q  <= valid_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_limb_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_limb_seq                                               |
// | Brief    : Scoreboard bench for alu_limb_seq (WORD_SIZE=64, LIMB=16).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_limb_seq;
  typedef struct {
    string       name;
    logic [63:0] res;
    logic        c;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   ready_bad = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_limb_seq_if #(.WORD_SIZE(64), .INSN(19), .IADDR(10)) bus ();

  alu_limb_seq #(.WORD_SIZE(64), .LIMB(16), .INSN(19), .IADDR(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each completion pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb.size() > 0 && !bus.o_valid && bus.o_ready && cyc >= sb[0].acc)
          ready_bad = 1'b1;
        if (bus.o_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(bus.o_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, bus.o_result, e.res);
            chk({e.name, "_carry"}, 64'(bus.o_carry), 64'(e.c));
            chk({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
            chk({e.name, "_ready_low"}, 64'(ready_bad), 64'd0);
            ready_bad = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input string name, input logic [4:0] op, input logic [8:0] off,
                       input logic [10:0] pc, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic [63:0] er, input logic ec,
                       input int lat, input bit expect_it);
    int n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.o_ready) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: got o_ready=0 expected 1", name);
      return;
    end
    bus.i_insn   = {op, 6'b0, off};
    bus.i_pc     = pc;
    bus.i_r1data = a;
    bus.i_r2data = b;
    bus.i_carry  = cin;
    bus.i_valid  = 1'b1;
    if (expect_it) sb.push_back('{name, er, ec, cyc + 1, lat});
    @(posedge clk);
    @(negedge clk);
    if (!expect_it) begin
      bus.i_valid = 1'b0;
      return;
    end
    // Keep a different request asserted while busy: it must neither disturb nor queue
    bus.i_insn   = {5'b00101, 6'b0, ~off};
    bus.i_pc     = ~pc;
    bus.i_r1data = ~a;
    bus.i_r2data = b + 64'd7;
    bus.i_carry  = ~cin;
    n = 0;
    while (!bus.o_valid && n < 200) begin @(negedge clk); n++; end
    if (!bus.o_valid) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got o_valid=0 expected 1", name);
    end
    bus.i_valid = 1'b0;
  endtask

  initial begin
    bit seen_valid;
    bus.i_valid = 1'b0; bus.i_insn = '0; bus.i_pc = '0;
    bus.i_r1data = '0; bus.i_r2data = '0; bus.i_carry = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(bus.o_ready), 64'd1);
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_result", bus.o_result, 64'd0);
    chk("reset_carry", 64'(bus.o_carry), 64'd0);
    rst = 1'b0;

    issue("add_wrap", 5'b00101, 9'h0, 11'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 5, 1);
    issue("add_chain", 5'b00101, 9'h0, 11'h0, 64'h0000_FFFF_0000_FFFF, 64'h1, 1'b1, 64'h0000_FFFF_0001_0000, 1'b0, 5, 1);
    issue("adc", 5'b00110, 9'h0, 11'h0, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b1, 64'h0000_0002_0000_0001, 1'b0, 5, 1);
    issue("sbb", 5'b01000, 9'h0, 11'h0, 64'h0000_0000_0001_0000, 64'h1, 1'b1, 64'h0000_0000_0000_FFFE, 1'b0, 5, 1);
    issue("sub_borrow", 5'b00111, 9'h0, 11'h0, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5, 1);
    issue("br_back", 5'b00001, 9'h1FE, 11'h005, 64'h0, 64'h0, 1'b0, 64'h3, 1'b0, 1, 1);
    issue("br_wrap", 5'b00100, 9'h001, 11'h7FF, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1, 1);
    issue("shr1", 5'b01101, 9'h0, 11'h0, 64'h8000_0000_0000_0001, 64'h0, 1'b1, 64'hC000_0000_0000_0000, 1'b1, 5, 1);
    issue("shl1", 5'b01100, 9'h0, 11'h0, 64'h8000_0000_0000_0001, 64'h0, 1'b1, 64'h0000_0000_0000_0003, 1'b1, 5, 1);
    issue("and", 5'b01001, 9'h0, 11'h0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 1'b0, 5, 1);
    issue("or", 5'b01010, 9'h0, 11'h0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 5, 1);
    issue("xor", 5'b01011, 9'h0, 11'h0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 5, 1);
    issue("nop", 5'b00000, 9'h1FF, 11'h123, 64'h1234, 64'h5678, 1'b1, 64'h0, 1'b0, 1, 1);
    issue("unknown", 5'b11111, 9'h0, 11'h0, 64'hFFFF, 64'hFFFF, 1'b1, 64'h0, 1'b0, 1, 1);
`ifdef ALU_LIMB_MUL_EN
    issue("mul", 5'b01110, 9'h0, 11'h0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0001, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 65, 1);
`else
    issue("mul_off", 5'b01110, 9'h0, 11'h0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0001, 1'b0, 64'h0, 1'b0, 1, 1);
`endif

    // Abort a shift in mid-run with reset
    issue("abort", 5'b01101, 9'h0, 11'h0, 64'h8000_0000_0000_0001, 64'h0, 1'b1, 64'h0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 64'(seen_valid), 64'd0);
    chk("abort_result", bus.o_result, 64'd0);
    chk("abort_carry", 64'(bus.o_carry), 64'd0);
    chk("abort_ready", 64'(bus.o_ready), 64'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
